// File: rtl/mdio_mem_readback.sv
// +--------------------------------------------------------------------------+
// | mdio_mem_readback : reads one capture-memory word per request and returns |
// | one selected 9-bit lane with a single-cycle valid pulse.  Rev 1.0         |
// +--------------------------------------------------------------------------+
`default_nettype none

module mdio_mem_readback #(
   parameter int NUM_PATH = 96,
   parameter int LANE_W   = 9,
   parameter int ADDR_W   = 15,
   parameter int SEL_W    = 7,
   parameter int RD_LAT   = 2,
   parameter int GAP_CYC  = 8
) (
   input  logic                       pktctrl_clk,
   input  logic                       pktctrl_rst,
   input  logic                       rf_mdio_read_pulse_sync,
   input  logic [SEL_W-1:0]           rf_mdio_data_sel_sync,
   input  logic [ADDR_W-1:0]          rf_mdio_memory_addr_sync,
   input  logic                       rf_96path_en_sync,
   input  logic                       capture_busy,
   output logic                       mem_rd_en,
   output logic [ADDR_W-1:0]          mem_rd_addr,
   input  logic [NUM_PATH*LANE_W-1:0] mem_rd_data,
   output logic                       mdio_read_pulse_r,
   output logic [LANE_W-1:0]          rf_mdio_pkt_data,
   output logic                       rd_busy,
   output logic                       sel_err,
   output logic                       drop_err
);

   localparam int LAT_W = 3;
   localparam int GAP_W = 8;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ARB  = 3'd1,
      S_WAIT = 3'd2,
      S_OUT  = 3'd3,
      S_GAP  = 3'd4
   } state_t;

   state_t              state_q,    state_d;
   logic [ADDR_W-1:0]   addr_q,     addr_d;
   logic [SEL_W-1:0]    sel_q,      sel_d;
   logic                en96_q,     en96_d;
   logic [LAT_W-1:0]    lat_cnt_q,  lat_cnt_d;
   logic [GAP_W-1:0]    gap_cnt_q,  gap_cnt_d;
   logic [LANE_W-1:0]   lane_q,     lane_d;
   logic                pulse_q,    pulse_d;
   logic [LANE_W-1:0]   pkt_data_q, pkt_data_d;
   logic                sel_err_q,  sel_err_d;
   logic                drop_err_q, drop_err_d;

   logic [LANE_W-1:0]   lane_sel;
   logic                sel_in_range;

   // Lane mux written as a constant-index loop so no part-select can run off the word
   always_comb begin
      lane_sel = '0;
      for (int k = 0; k < NUM_PATH; k++) begin
         if (sel_q == SEL_W'(k)) begin
            lane_sel = mem_rd_data[k*LANE_W +: LANE_W];
         end
      end
   end

   assign sel_in_range = en96_q ? (int'(sel_q) < NUM_PATH)
                                : (int'(sel_q) < (NUM_PATH / 2));

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      sel_d      = sel_q;
      en96_d     = en96_q;
      lat_cnt_d  = lat_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      lane_d     = lane_q;
      pulse_d    = 1'b0;
      pkt_data_d = pkt_data_q;
      sel_err_d  = sel_err_q;
      drop_err_d = drop_err_q;
      mem_rd_en  = 1'b0;

      if (rf_mdio_read_pulse_sync && (state_q != S_IDLE)) begin
         drop_err_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (rf_mdio_read_pulse_sync) begin
               addr_d  = rf_mdio_memory_addr_sync;
               sel_d   = rf_mdio_data_sel_sync;
               en96_d  = rf_96path_en_sync;
               state_d = S_ARB;
            end
         end
         S_ARB: begin
            // Read strobe is gated combinationally so it can never coincide with capture_busy
            if (!capture_busy) begin
               mem_rd_en = 1'b1;
               lat_cnt_d = LAT_W'(RD_LAT);
               state_d   = S_WAIT;
            end
         end
         S_WAIT: begin
            if (lat_cnt_q == LAT_W'(1)) begin
               lane_d = sel_in_range ? lane_sel : '0;
               if (!sel_in_range) begin
                  sel_err_d = 1'b1;
               end
               state_d = S_OUT;
            end else begin
               lat_cnt_d = lat_cnt_q - LAT_W'(1);
            end
         end
         S_OUT: begin
            pulse_d    = 1'b1;
            pkt_data_d = lane_q;
            gap_cnt_d  = GAP_W'(GAP_CYC);
            state_d    = S_GAP;
         end
         S_GAP: begin
            if (gap_cnt_q == GAP_W'(1)) begin
               state_d = S_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q - GAP_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge pktctrl_clk) begin
      if (pktctrl_rst) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         sel_q      <= '0;
         en96_q     <= 1'b0;
         lat_cnt_q  <= '0;
         gap_cnt_q  <= '0;
         lane_q     <= '0;
         pulse_q    <= 1'b0;
         pkt_data_q <= '0;
         sel_err_q  <= 1'b0;
         drop_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         sel_q      <= sel_d;
         en96_q     <= en96_d;
         lat_cnt_q  <= lat_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         lane_q     <= lane_d;
         pulse_q    <= pulse_d;
         pkt_data_q <= pkt_data_d;
         sel_err_q  <= sel_err_d;
         drop_err_q <= drop_err_d;
      end
   end

   assign mem_rd_addr       = addr_q;
   assign mdio_read_pulse_r = pulse_q;
   assign rf_mdio_pkt_data  = pkt_data_q;
   assign rd_busy           = (state_q != S_IDLE);
   assign sel_err           = sel_err_q;
   assign drop_err          = drop_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mdio_mem_readback.sv
// Directed table-driven bench for mdio_mem_readback with a 2-cycle-latency memory model.
`default_nettype none

module tb_mdio_mem_readback;

   localparam int NP = 96;
   localparam int LW = 9;
   localparam int AW = 15;
   localparam int SW = 7;
   localparam int DW = NP * LW;

   logic          clk = 1'b0;
   logic          rst;
   logic          rd_pulse;
   logic [SW-1:0] sel_in;
   logic [AW-1:0] addr_in;
   logic          en96_in;
   logic          cap_busy;
   logic          mem_rd_en;
   logic [AW-1:0] mem_rd_addr;
   logic [DW-1:0] mem_rd_data;
   logic          pulse_r;
   logic [LW-1:0] pkt_data;
   logic          rd_busy;
   logic          sel_err;
   logic          drop_err;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mdio_mem_readback dut (
      .pktctrl_clk              (clk),
      .pktctrl_rst              (rst),
      .rf_mdio_read_pulse_sync  (rd_pulse),
      .rf_mdio_data_sel_sync    (sel_in),
      .rf_mdio_memory_addr_sync (addr_in),
      .rf_96path_en_sync        (en96_in),
      .capture_busy             (cap_busy),
      .mem_rd_en                (mem_rd_en),
      .mem_rd_addr              (mem_rd_addr),
      .mem_rd_data              (mem_rd_data),
      .mdio_read_pulse_r        (pulse_r),
      .rf_mdio_pkt_data         (pkt_data),
      .rd_busy                  (rd_busy),
      .sel_err                  (sel_err),
      .drop_err                 (drop_err)
   );

   // Memory model: the word at cur_addr is valid exactly 2 cycles after the strobe
   logic [DW-1:0] cur_word;
   logic [AW-1:0] cur_addr;
   logic [DW-1:0] junk_word;
   logic          en_d1 = 1'b0, en_d2 = 1'b0;
   logic [AW-1:0] a_d1 = '0, a_d2 = '0;

   always @(posedge clk) begin
      en_d1 <= mem_rd_en;
      en_d2 <= en_d1;
      a_d1  <= mem_rd_addr;
      a_d2  <= a_d1;
   end

   assign mem_rd_data = (en_d2 && (a_d2 == cur_addr)) ? cur_word : junk_word;

   function automatic logic [DW-1:0] make_pat(input int p);
      logic [DW-1:0] w;
      logic [LW-1:0] v;
      w = '0;
      for (int k = 0; k < NP; k++) begin
         case (p)
            0:       v = LW'(k + 1);
            1:       v = (k == 0) ? 9'h1FF : ((k == 95) ? 9'h155 : 9'h000);
            2:       v = (k == 0) ? 9'h000 : ((k == 95) ? 9'h0AA : 9'h1FF);
            default: v = 9'h133;
         endcase
         w[k*LW +: LW] = v;
      end
      return w;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction with no contention; cycle numbers are relative to the request cycle
   task automatic do_read(input string nm, input logic [SW-1:0] s, input logic [AW-1:0] a,
                          input logic e, input logic [LW-1:0] exp_d, input logic exp_se);
      int cyc;
      int extra_en;
      bit found;
      sel_in   = s;
      addr_in  = a;
      en96_in  = e;
      rd_pulse = 1'b1;
      tick();
      rd_pulse = 1'b0;
      sel_in   = s ^ 7'h55;
      addr_in  = ~a;
      en96_in  = ~e;
      cyc      = 1;
      chk({nm, "_rd_en"}, 32'(mem_rd_en), 32'd1);
      chk({nm, "_rd_addr"}, 32'(mem_rd_addr), 32'(a));
      chk({nm, "_busy_rise"}, 32'(rd_busy), 32'd1);
      found    = 1'b0;
      extra_en = 0;
      while (!found && cyc < 12) begin
         tick();
         cyc++;
         if (mem_rd_en) extra_en++;
         if (pulse_r) found = 1'b1;
      end
      chk({nm, "_latency"}, 32'(cyc), 32'd5);
      chk({nm, "_extra_rd_en"}, 32'(extra_en), 32'd0);
      if (found) begin
         chk({nm, "_data"}, 32'(pkt_data), 32'(exp_d));
         chk({nm, "_sel_err"}, 32'(sel_err), 32'(exp_se));
         tick();
         cyc++;
         chk({nm, "_pulse_width"}, 32'(pulse_r), 32'd0);
         chk({nm, "_data_hold"}, 32'(pkt_data), 32'(exp_d));
         while (rd_busy && cyc < 30) begin
            tick();
            cyc++;
         end
         chk({nm, "_busy_fall"}, 32'(cyc), 32'd13);
      end
   endtask

   typedef struct {
      int            pat;
      logic [AW-1:0] addr;
      logic          en;
      logic [SW-1:0] sel;
      logic [LW-1:0] exp_data;
      logic          exp_se;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int cnt;
      int cnt2;
      int cnt3;

      junk_word = make_pat(3);
      cur_word  = make_pat(0);
      cur_addr  = 15'h0123;

      vecs[0] = '{0, 15'h0123, 1'b1, 7'd5,   9'h006, 1'b0};
      vecs[1] = '{0, 15'h0123, 1'b0, 7'd47,  9'h030, 1'b0};
      vecs[2] = '{0, 15'h0123, 1'b0, 7'd48,  9'h000, 1'b1};
      vecs[3] = '{0, 15'h0123, 1'b1, 7'd95,  9'h060, 1'b1};
      vecs[4] = '{0, 15'h0123, 1'b0, 7'd100, 9'h000, 1'b1};
      vecs[5] = '{1, 15'h7FFF, 1'b1, 7'd0,   9'h1FF, 1'b1};
      vecs[6] = '{1, 15'h7FFF, 1'b1, 7'd95,  9'h155, 1'b1};
      vecs[7] = '{2, 15'h0000, 1'b1, 7'd0,   9'h000, 1'b1};
      vecs[8] = '{2, 15'h0000, 1'b1, 7'd95,  9'h0AA, 1'b1};
      vecs[9] = '{2, 15'h0000, 1'b1, 7'd1,   9'h1FF, 1'b1};

      rst      = 1'b1;
      rd_pulse = 1'b0;
      sel_in   = '0;
      addr_in  = '0;
      en96_in  = 1'b0;
      cap_busy = 1'b0;
      repeat (3) tick();
      rst = 1'b0;

      chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
      chk("rst_rd_addr", 32'(mem_rd_addr), 32'd0);
      chk("rst_pulse", 32'(pulse_r), 32'd0);
      chk("rst_data", 32'(pkt_data), 32'd0);
      chk("rst_busy", 32'(rd_busy), 32'd0);
      chk("rst_sel_err", 32'(sel_err), 32'd0);
      chk("rst_drop_err", 32'(drop_err), 32'd0);

      for (int i = 0; i < 10; i++) begin
         cur_word = make_pat(vecs[i].pat);
         cur_addr = vecs[i].addr;
         do_read($sformatf("vec%0d", i), vecs[i].sel, vecs[i].addr, vecs[i].en,
                 vecs[i].exp_data, vecs[i].exp_se);
         tick();
      end
      chk("vec_drop_err", 32'(drop_err), 32'd0);

      // Arbitration stall: capture owns the memory for 20 cycles around the request
      cur_word = make_pat(0);
      cur_addr = 15'h0456;
      cap_busy = 1'b1;
      tick();
      sel_in   = 7'd10;
      addr_in  = 15'h0456;
      en96_in  = 1'b1;
      rd_pulse = 1'b1;
      tick();
      rd_pulse = 1'b0;
      cnt = 0;
      for (int i = 0; i < 18; i++) begin
         if (mem_rd_en) cnt++;
         tick();
      end
      chk("stall_no_rd_en", 32'(cnt), 32'd0);
      chk("stall_busy", 32'(rd_busy), 32'd1);
      cap_busy = 1'b0;
      #1;
      chk("stall_rd_en_release", 32'(mem_rd_en), 32'd1);
      chk("stall_rd_addr", 32'(mem_rd_addr), 32'h0456);
      cnt = 0;
      while (!pulse_r && cnt < 12) begin
         tick();
         cnt++;
      end
      chk("stall_latency", 32'(cnt), 32'd4);
      chk("stall_data", 32'(pkt_data), 32'h00B);
      cnt = 0;
      while (rd_busy && cnt < 30) begin
         tick();
         cnt++;
      end
      chk("stall_idle", 32'(rd_busy), 32'd0);

      // Drop: second request in WAIT, third in the final GAP cycle
      rst = 1'b1;
      tick();
      rst = 1'b0;
      cur_word = make_pat(0);
      cur_addr = 15'h0ABC;
      sel_in   = 7'd3;
      addr_in  = 15'h0ABC;
      en96_in  = 1'b1;
      rd_pulse = 1'b1;
      tick();
      rd_pulse = 1'b0;
      tick();
      sel_in   = 7'd9;
      addr_in  = 15'h0111;
      rd_pulse = 1'b1;
      tick();
      rd_pulse = 1'b0;
      chk("drop_err_set", 32'(drop_err), 32'd1);
      tick();
      tick();
      chk("drop_pulse", 32'(pulse_r), 32'd1);
      chk("drop_data", 32'(pkt_data), 32'h004);
      chk("drop_addr", 32'(mem_rd_addr), 32'h0ABC);
      repeat (7) tick();
      chk("drop_last_gap_busy", 32'(rd_busy), 32'd1);
      rd_pulse = 1'b1;
      tick();
      rd_pulse = 1'b0;
      chk("drop_gap_idle", 32'(rd_busy), 32'd0);
      cnt = 0;
      cnt2 = 0;
      cnt3 = 0;
      for (int i = 0; i < 20; i++) begin
         if (pulse_r) cnt++;
         if (mem_rd_en) cnt2++;
         if (rd_busy) cnt3++;
         tick();
      end
      chk("drop_no_pulse", 32'(cnt), 32'd0);
      chk("drop_no_rd_en", 32'(cnt2), 32'd0);
      chk("drop_stays_idle", 32'(cnt3), 32'd0);
      chk("drop_err_sticky", 32'(drop_err), 32'd1);

      // Reset while waiting on memory data
      cur_word = make_pat(0);
      cur_addr = 15'h0123;
      sel_in   = 7'd50;
      addr_in  = 15'h0123;
      en96_in  = 1'b0;
      rd_pulse = 1'b1;
      tick();
      rd_pulse = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_busy", 32'(rd_busy), 32'd0);
      chk("mid_rst_rd_en", 32'(mem_rd_en), 32'd0);
      chk("mid_rst_rd_addr", 32'(mem_rd_addr), 32'd0);
      chk("mid_rst_pulse", 32'(pulse_r), 32'd0);
      chk("mid_rst_data", 32'(pkt_data), 32'd0);
      chk("mid_rst_drop_err", 32'(drop_err), 32'd0);
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         if (pulse_r) cnt++;
         tick();
      end
      chk("mid_rst_no_pulse", 32'(cnt), 32'd0);
      chk("mid_rst_sel_err", 32'(sel_err), 32'd0);
      do_read("after_rst", 7'd20, 15'h0123, 1'b1, 9'h015, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
